alu_8bit: RTL and testbench



---
 rtl/alu_8bit.sv | 68 ++++++
 tb/tb_alu_8bit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
`default_nettype none
// ============================================================================
// Module   : alu_8bit
// Brief    : 8-bit registered ALU with zero flag. Optional opcodes 100-111
//            (SUB/XOR/SLL/SRL) are built only when ALU_EXT_OPS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_8bit (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
    input  logic [2:0] SELECT,
    output logic [7:0] RESULT,
    output logic       ZERO
);

    localparam logic [2:0] c_op_fwd = 3'b000;
    localparam logic [2:0] c_op_add = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_or  = 3'b011;
`ifdef ALU_EXT_OPS_EN
    localparam logic [2:0] c_op_sub = 3'b100;
    localparam logic [2:0] c_op_xor = 3'b101;
    localparam logic [2:0] c_op_sll = 3'b110;
    localparam logic [2:0] c_op_srl = 3'b111;
`endif

    logic [7:0] w_next_result;
    logic       w_next_zero;
    logic [7:0] r_result;
    logic       r_zero;

    always_comb begin
        w_next_result = 8'h00;
        case (SELECT)
            c_op_fwd: w_next_result = DATA2;
            c_op_add: w_next_result = DATA1 + DATA2;
            c_op_and: w_next_result = DATA1 & DATA2;
            c_op_or:  w_next_result = DATA1 | DATA2;
`ifdef ALU_EXT_OPS_EN
            c_op_sub: w_next_result = DATA1 - DATA2;
            c_op_xor: w_next_result = DATA1 ^ DATA2;
            c_op_sll: w_next_result = DATA1 << DATA2[2:0];
            c_op_srl: w_next_result = DATA1 >> DATA2[2:0];
`endif
            default:  w_next_result = 8'h00;
        endcase
    end

    // Flag derived from the same next value so it always tracks RESULT.
    assign w_next_zero = (w_next_result == 8'h00);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_result <= 8'h00;
            r_zero   <= 1'b1;
        end else begin
            r_result <= w_next_result;
            r_zero   <= w_next_zero;
        end
    end

    assign RESULT = r_result;
    assign ZERO   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_8bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_8bit
// Brief    : Directed self-checking bench for alu_8bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_8bit;

    logic       CLK;
    logic       RESET;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [2:0] SELECT;
    logic [7:0] RESULT;
    logic       ZERO;

    int r_checks = 0;
    int r_passed = 0;

    alu_8bit u_dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .SELECT (SELECT),
        .RESULT (RESULT),
        .ZERO   (ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        r_checks++;
        if (obs === exp) r_passed++;
        else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    endtask

    // Drive on the falling edge, capture on the next rising edge, sample 1 later.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        @(negedge CLK);
        DATA1  = a;
        DATA2  = b;
        SELECT = s;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET  = 1'b1;
        DATA1  = 8'h00;
        DATA2  = 8'h00;
        SELECT = 3'b000;
        #1;
        check("rst_result", RESULT, 8'h00);
        check("rst_zero", {7'b0, ZERO}, 8'h01);
        @(negedge CLK);
        RESET = 1'b0;

        // Async reset while holding 0x55
        op(8'h00, 8'h55, 3'b000);
        check("fwd55", RESULT, 8'h55);
        check("fwd55_zero", {7'b0, ZERO}, 8'h00);
        #2 RESET = 1'b1;
        #1;
        check("async_rst_result", RESULT, 8'h00);
        check("async_rst_zero", {7'b0, ZERO}, 8'h01);
        @(negedge CLK);
        RESET = 1'b0;
        op(8'd1, 8'd2, 3'b001);
        check("post_rst_add", RESULT, 8'd3);
        check("post_rst_add_zero", {7'b0, ZERO}, 8'h00);

        // Base ops back to back
        op(8'd12, 8'd8, 3'b010);
        check("and", RESULT, 8'd8);
        op(8'd2, 8'd1, 3'b011);
        check("or", RESULT, 8'd3);
        op(8'd2, 8'd12, 3'b000);
        check("fwd", RESULT, 8'd12);
        op(8'hF0, 8'h0F, 3'b010);
        check("and_zero", RESULT, 8'h00);
        check("and_zero_flag", {7'b0, ZERO}, 8'h01);

        // Wrap-around
        op(8'd255, 8'd1, 3'b001);
        check("wrap_result", RESULT, 8'h00);
        check("wrap_zero", {7'b0, ZERO}, 8'h01);
        op(8'd200, 8'd100, 3'b001);
        check("wrap_44", RESULT, 8'd44);

        // Mid-cycle SELECT glitch must not disturb outputs
        op(8'd1, 8'd2, 3'b001);
        check("glitch_pre", RESULT, 8'd3);
        #1 SELECT = 3'b010;
        #1;
        check("glitch_mid", RESULT, 8'd3);
        check("glitch_mid_zero", {7'b0, ZERO}, 8'h00);
        #1 SELECT = 3'b001;
        @(posedge CLK);
        #1;
        check("glitch_post", RESULT, 8'd3);

        // Extended opcodes
`ifdef ALU_EXT_OPS_EN
        op(8'd5, 8'd7, 3'b100);
        check("sub", RESULT, 8'hFE);
        op(8'd5, 8'd7, 3'b101);
        check("xor", RESULT, 8'h02);
        op(8'h81, 8'd1, 3'b110);
        check("sll", RESULT, 8'h02);
        op(8'h81, 8'd1, 3'b111);
        check("srl", RESULT, 8'h40);
        op(8'd5, 8'd5, 3'b100);
        check("sub_zero", {7'b0, ZERO}, 8'h01);
`else
        for (int i = 4; i < 8; i++) begin
            op(8'd5, 8'd7, 3'(i));
            check($sformatf("ext%0d_result", i), RESULT, 8'h00);
            check($sformatf("ext%0d_zero", i), {7'b0, ZERO}, 8'h01);
        end
`endif

        // Reset between two ADD cycles discards the in-flight result
        op(8'd10, 8'd20, 3'b001);
        check("add30", RESULT, 8'd30);
        @(negedge CLK);
        DATA1  = 8'd40;
        DATA2  = 8'd50;
        SELECT = 3'b001;
        #2 RESET = 1'b1;
        #1;
        check("mid_rst_now", RESULT, 8'h00);
        check("mid_rst_zero", {7'b0, ZERO}, 8'h01);
        @(posedge CLK);
        #1;
        check("mid_rst_held", RESULT, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("mid_rst_released", RESULT, 8'h00);
        op(8'd7, 8'd8, 3'b001);
        check("after_mid_rst", RESULT, 8'd15);

        $display("%0d/%0d checks passed", r_passed, r_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
